// File: rtl/uart_tx.sv
// 8N1 UART transmitter with registered line output and a one-cycle tx_done pulse.
// Defining UART_TX_PARITY_EN adds an even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] parallel_in,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       tx_done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W        = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               serial_out_q, serial_out_d;
  logic               tx_ready_q, tx_ready_d;
  logic               tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic bit_end;
  logic accept;

  assign bit_end = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
  assign accept  = tx_start && tx_ready_q;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    serial_out_d = serial_out_q;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = START;
          baud_d       = '0;
          shift_d      = parallel_in;
          serial_out_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d     = ^parallel_in;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d      = DATA;
          baud_d       = '0;
          bit_idx_d    = '0;
          serial_out_d = shift_q[0];
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx_q == IDX_W'(7)) begin
`ifdef UART_TX_PARITY_EN
            state_d      = PARITY;
            serial_out_d = parity_q;
`else
            state_d      = STOP;
            serial_out_d = 1'b1;
`endif
          end else begin
            bit_idx_d    = bit_idx_q + IDX_W'(1);
            shift_d      = shift_q >> 1;
            serial_out_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d      = STOP;
          baud_d       = '0;
          serial_out_d = 1'b1;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // A request in the last stop cycle chains straight into the next start bit
          if (accept) begin
            state_d      = START;
            shift_d      = parallel_in;
            serial_out_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d     = ^parallel_in;
`endif
          end else begin
            state_d      = IDLE;
            serial_out_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d      = IDLE;
        baud_d       = '0;
        serial_out_d = 1'b1;
      end
    endcase

    tx_done_d  = (state_d == STOP) && (baud_d == CNT_W'(CLKS_PER_BIT - 1));
    tx_ready_d = (state_d == IDLE) || tx_done_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      serial_out_q <= 1'b1;
      tx_ready_q   <= 1'b1;
      tx_done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      serial_out_q <= serial_out_d;
      tx_ready_q   <= tx_ready_d;
      tx_done_q    <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign serial_out = serial_out_q;
  assign tx_ready   = tx_ready_q;
  assign tx_done    = tx_done_q;

endmodule
